branch_outcome_retire_queue: RTL and testbench

In-order retirement queue that feeds resolved branch outcomes to the global history register. Branches allocate an entry in program order at predict time, resolve out of order from the execution units by tag, and retire strictly in program order. Each retirement drives one `update_enable` / `new_branch_outcome` pulse on the GHR update interface, so the history register shifts only in program order.

---
 rtl/branch_outcome_retire_queue_if.sv | 27 ++
 rtl/branch_outcome_retire_queue.sv | 110 +++++++++++
 tb/tb_branch_outcome_retire_queue.sv | 281 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/branch_outcome_retire_queue_if.sv
// Handshake bundle between branch predict/resolve logic and the outcome retire queue.
// The queue takes the slave side; the producer/consumer of branch outcomes takes master.
interface branch_outcome_retire_queue_if #(
  parameter int DEPTH     = 16,
  parameter int TAG_WIDTH = $clog2(DEPTH)
);
  logic                 alloc_valid;
  logic                 alloc_ready;
  logic [TAG_WIDTH-1:0] alloc_tag;
  logic                 resolve_valid;
  logic [TAG_WIDTH-1:0] resolve_tag;
  logic                 resolve_taken;
  logic                 flush;
  logic                 update_enable;
  logic                 new_branch_outcome;
  logic [TAG_WIDTH:0]   count;

  modport master (
    output alloc_valid, resolve_valid, resolve_tag, resolve_taken, flush,
    input  alloc_ready, alloc_tag, update_enable, new_branch_outcome, count
  );

  modport slave (
    input  alloc_valid, resolve_valid, resolve_tag, resolve_taken, flush,
    output alloc_ready, alloc_tag, update_enable, new_branch_outcome, count
  );
endinterface

// File: rtl/branch_outcome_retire_queue.sv
// In-order retire queue for resolved branch outcomes feeding the GHR update port.
// Optional flush support is compiled in with `define OUTCOME_QUEUE_FLUSH_EN.
module branch_outcome_retire_queue #(
  parameter int DEPTH     = 16,
  parameter int TAG_WIDTH = $clog2(DEPTH)
) (
  input  logic                          clk,
  input  logic                          rst,
  branch_outcome_retire_queue_if.slave  bus
);

  localparam logic [TAG_WIDTH:0] FULL_COUNT = (TAG_WIDTH+1)'(DEPTH);

  logic [DEPTH-1:0]     alloc_q, alloc_d;
  logic [DEPTH-1:0]     resolved_q, resolved_d;
  logic [DEPTH-1:0]     taken_q, taken_d;
  logic [TAG_WIDTH-1:0] head_q, head_d;
  logic [TAG_WIDTH-1:0] tail_q, tail_d;
  logic [TAG_WIDTH:0]   count_q, count_d;
  logic                 upd_q, upd_d;
  logic                 outcome_q, outcome_d;

  logic full;
  logic do_alloc;
  logic do_resolve;
  logic do_retire;

  assign full       = (count_q == FULL_COUNT);
  assign do_alloc   = bus.alloc_valid && !full;
  assign do_resolve = bus.resolve_valid && alloc_q[bus.resolve_tag] && !resolved_q[bus.resolve_tag];
  assign do_retire  = alloc_q[head_q] && resolved_q[head_q];

  always_comb begin
    alloc_d    = alloc_q;
    resolved_d = resolved_q;
    taken_d    = taken_q;
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;
    upd_d      = 1'b0;
    outcome_d  = outcome_q;

    if (do_resolve) begin
      resolved_d[bus.resolve_tag] = 1'b1;
      taken_d[bus.resolve_tag]    = bus.resolve_taken;
    end

    // Retire decision uses registered state only, so a same-cycle resolve of the head waits one edge.
    if (do_retire) begin
      alloc_d[head_q] = 1'b0;
      head_d          = head_q + 1'b1;
      upd_d           = 1'b1;
      outcome_d       = taken_q[head_q];
    end

    // tail never equals head here: allocation is blocked when full and retire needs a non-empty queue.
    if (do_alloc) begin
      alloc_d[tail_q]    = 1'b1;
      resolved_d[tail_q] = 1'b0;
      tail_d             = tail_q + 1'b1;
    end

    case ({do_alloc, do_retire})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

`ifdef OUTCOME_QUEUE_FLUSH_EN
    if (bus.flush) begin
      alloc_d    = '0;
      resolved_d = '0;
      head_d     = '0;
      tail_d     = '0;
      count_d    = '0;
      upd_d      = 1'b0;
      outcome_d  = outcome_q;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      alloc_q    <= '0;
      resolved_q <= '0;
      taken_q    <= '0;
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      upd_q      <= 1'b0;
      outcome_q  <= 1'b0;
    end else begin
      alloc_q    <= alloc_d;
      resolved_q <= resolved_d;
      taken_q    <= taken_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      upd_q      <= upd_d;
      outcome_q  <= outcome_d;
    end
  end

  assign bus.alloc_ready        = !full;
  assign bus.alloc_tag          = tail_q;
  assign bus.count              = count_q;
  assign bus.update_enable      = upd_q;
  assign bus.new_branch_outcome = outcome_q;

endmodule

// File: tb/tb_branch_outcome_retire_queue.sv
// Bench for branch_outcome_retire_queue: directed scenarios with literal expectations plus
// randomized traffic checked every cycle against a queue-based model of in-flight branches.
module tb_branch_outcome_retire_queue;
  localparam int DEPTH = 16;
  localparam int TW    = $clog2(DEPTH);

  logic clk;
  logic rst;

  branch_outcome_retire_queue_if #(.DEPTH(DEPTH)) bus ();

  branch_outcome_retire_queue #(.DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_mis = 0;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_mis++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  // Model: in-flight branches in program order; the front is the oldest.
  typedef struct {
    int tag;
    bit resolved;
    bit taken;
  } ent_t;

  ent_t mq[$];
  int   m_tail     = 0;
  bit   exp_upd    = 1'b0;
  bit   exp_out    = 1'b0;
  bit   model_live = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      mq.delete();
      m_tail     = 0;
      exp_upd    = 1'b0;
      exp_out    = 1'b0;
      model_live = 1'b1;
    end else begin
      bit ret;
      bit was_full;
      bit flushing;
      ret      = (mq.size() > 0) && mq[0].resolved;
      was_full = (mq.size() == DEPTH);
      flushing = 1'b0;
`ifdef OUTCOME_QUEUE_FLUSH_EN
      flushing = bus.flush;
`endif
      if (flushing) begin
        mq.delete();
        m_tail  = 0;
        exp_upd = 1'b0;
      end else begin
        if (bus.resolve_valid) begin
          foreach (mq[i]) begin
            if (mq[i].tag == int'(bus.resolve_tag) && !mq[i].resolved) begin
              mq[i].resolved = 1'b1;
              mq[i].taken    = bus.resolve_taken;
            end
          end
        end
        if (ret) begin
          exp_upd = 1'b1;
          exp_out = mq[0].taken;
          void'(mq.pop_front());
        end else begin
          exp_upd = 1'b0;
        end
        if (bus.alloc_valid && !was_full) begin
          mq.push_back('{tag: m_tail, resolved: 1'b0, taken: 1'b0});
          m_tail = (m_tail + 1) % DEPTH;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (model_live) begin
      check("model_count", int'(bus.count), mq.size());
      check("model_alloc_ready", int'(bus.alloc_ready), int'(mq.size() < DEPTH));
      check("model_alloc_tag", int'(bus.alloc_tag), m_tail);
      check("model_update_enable", int'(bus.update_enable), int'(exp_upd));
      if (exp_upd) check("model_outcome", int'(bus.new_branch_outcome), int'(exp_out));
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    bus.alloc_valid   = 1'b0;
    bus.resolve_valid = 1'b0;
    bus.resolve_tag   = '0;
    bus.resolve_taken = 1'b0;
    bus.flush         = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic resolve(input int tag, input bit tk);
    bus.resolve_valid = 1'b1;
    bus.resolve_tag   = TW'(tag);
    bus.resolve_taken = tk;
  endtask

  task automatic alloc_n(input int n);
    bus.alloc_valid = 1'b1;
    for (int i = 0; i < n; i++) tick();
    bus.alloc_valid = 1'b0;
  endtask

  task automatic expect_upd(input string name, input bit upd, input bit outc);
    check({name, "_upd"}, int'(bus.update_enable), int'(upd));
    if (upd) check({name, "_out"}, int'(bus.new_branch_outcome), int'(outc));
  endtask

  initial begin
    rst = 1'b0;
    idle_inputs();
    @(negedge clk);

    // Reset then idle
    do_reset();
    check("rst_count", int'(bus.count), 0);
    check("rst_ready", int'(bus.alloc_ready), 1);
    check("rst_tag", int'(bus.alloc_tag), 0);
    check("rst_outcome", int'(bus.new_branch_outcome), 0);
    for (int i = 0; i < 10; i++) begin
      tick();
      check("idle_upd", int'(bus.update_enable), 0);
      check("idle_count", int'(bus.count), 0);
    end

    // In-order T,N,T
    do_reset();
    for (int i = 0; i < 3; i++) begin
      check("io_alloc_tag", int'(bus.alloc_tag), i);
      bus.alloc_valid = 1'b1;
      tick();
    end
    bus.alloc_valid = 1'b0;
    check("io_count3", int'(bus.count), 3);
    check("io_model_size", mq.size(), 3);
    resolve(0, 1'b1); tick(); expect_upd("io_e0", 1'b0, 1'b0);
    resolve(1, 1'b0); tick(); expect_upd("io_e1", 1'b1, 1'b1);
    resolve(2, 1'b1); tick(); expect_upd("io_e2", 1'b1, 1'b0);
    idle_inputs();    tick(); expect_upd("io_e3", 1'b1, 1'b1);
    tick();                   expect_upd("io_e4", 1'b0, 1'b0);
    check("io_count0", int'(bus.count), 0);

    // Out-of-order resolves drain in program order
    do_reset();
    alloc_n(4);
    resolve(3, 1'b1); tick(); expect_upd("oo_r3", 1'b0, 1'b0);
    resolve(2, 1'b0); tick(); expect_upd("oo_r2", 1'b0, 1'b0);
    resolve(1, 1'b1); tick(); expect_upd("oo_r1", 1'b0, 1'b0);
    resolve(0, 1'b0); tick(); expect_upd("oo_r0", 1'b0, 1'b0);
    idle_inputs();
    tick(); expect_upd("oo_d0", 1'b1, 1'b0);
    check("oo_model_out", int'(exp_out), 0);
    tick(); expect_upd("oo_d1", 1'b1, 1'b1);
    tick(); expect_upd("oo_d2", 1'b1, 1'b0);
    tick(); expect_upd("oo_d3", 1'b1, 1'b1);
    tick(); expect_upd("oo_d4", 1'b0, 1'b0);
    check("oo_count0", int'(bus.count), 0);

    // Full and wrap
    do_reset();
    alloc_n(DEPTH);
    check("full_ready", int'(bus.alloc_ready), 0);
    check("full_count", int'(bus.count), DEPTH);
    check("full_tag", int'(bus.alloc_tag), 0);
    alloc_n(1);
    check("full_ignored_count", int'(bus.count), DEPTH);
    check("full_model_size", mq.size(), DEPTH);
    resolve(0, 1'b1); tick();
    check("full_res_count", int'(bus.count), DEPTH);
    idle_inputs(); tick();
    expect_upd("full_retire", 1'b1, 1'b1);
    check("full_after_ret_count", int'(bus.count), DEPTH - 1);
    check("full_after_ret_ready", int'(bus.alloc_ready), 1);
    check("wrap_tag", int'(bus.alloc_tag), 0);
    alloc_n(1);
    check("wrap_count", int'(bus.count), DEPTH);
    check("wrap_ready", int'(bus.alloc_ready), 0);

    // Illegal resolves leave state untouched
    do_reset();
    resolve(5, 1'b1); tick();
    check("ill_empty_count", int'(bus.count), 0);
    idle_inputs(); tick();
    expect_upd("ill_empty", 1'b0, 1'b0);
    check("ill_empty_tag", int'(bus.alloc_tag), 0);
    alloc_n(2);
    resolve(1, 1'b1); tick(); expect_upd("ill_a", 1'b0, 1'b0);
    resolve(1, 1'b0); tick(); expect_upd("ill_b", 1'b0, 1'b0);
    resolve(0, 1'b0); tick(); expect_upd("ill_c", 1'b0, 1'b0);
    resolve(0, 1'b1); tick(); expect_upd("ill_t0", 1'b1, 1'b0);
    idle_inputs();    tick(); expect_upd("ill_t1", 1'b1, 1'b1);
    tick();                   expect_upd("ill_end", 1'b0, 1'b0);
    check("ill_count0", int'(bus.count), 0);

    // Flush with six in flight, tags 1 and 2 resolved
    do_reset();
    alloc_n(6);
    resolve(1, 1'b1); tick();
    resolve(2, 1'b0); tick();
    check("fl_pre_count", int'(bus.count), 6);
    bus.flush       = 1'b1;
    bus.alloc_valid = 1'b1;
    resolve(3, 1'b1);
    tick();
    idle_inputs();
`ifdef OUTCOME_QUEUE_FLUSH_EN
    check("fl_count", int'(bus.count), 0);
    check("fl_tag", int'(bus.alloc_tag), 0);
`else
    // flush is ignored, so the concurrent allocation is accepted normally
    check("fl_count", int'(bus.count), 7);
    check("fl_tag", int'(bus.alloc_tag), 7);
`endif
    check("fl_upd", int'(bus.update_enable), 0);
    tick();
    check("fl_upd2", int'(bus.update_enable), 0);

    // Randomized traffic: fill-biased phase then drain-biased phase
    do_reset();
    for (int ph = 0; ph < 4; ph++) begin
      int ap;
      int rp;
      ap = (ph % 2 == 0) ? 85 : 30;
      rp = (ph % 2 == 0) ? 35 : 90;
      for (int c = 0; c < 700; c++) begin
        bus.alloc_valid   = ($urandom_range(0, 99) < ap);
        bus.resolve_valid = ($urandom_range(0, 99) < rp);
        if (mq.size() > 0 && $urandom_range(0, 3) != 0)
          bus.resolve_tag = TW'(mq[$urandom_range(0, mq.size() - 1)].tag);
        else
          bus.resolve_tag = TW'($urandom_range(0, DEPTH - 1));
        bus.resolve_taken = 1'($urandom_range(0, 1));
        bus.flush         = ($urandom_range(0, 149) == 0);
        rst               = ($urandom_range(0, 399) == 0);
        tick();
      end
    end
    rst = 1'b0;
    idle_inputs();
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
